// File: rtl/ltable_scan_ctrl.sv
// ltable_scan_ctrl: round-robin slot scheduler that produces the 3-bit
// nowCount select for the one-hot lamp/channel table decoder. It serves six
// channels plus an all-on slot (count 6). Every output is registered.
module ltable_scan_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [5:0]         req_mask,
    input  logic               all_on,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         nowCount,
    output logic               slot_valid,
    output logic               slot_start,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CHAN = 2'd1,
        S_ALL  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         last_reg, last_next;
    logic [DWELL_W-1:0] timer_reg, timer_next;
    logic               wrap_pending_reg, wrap_pending_next;
    logic [2:0]         now_reg, now_next;
    logic               valid_reg, valid_next;
    logic               start_reg, start_next;
    logic               frame_reg, frame_next;

    // A decision is taken on every IDLE cycle and on the last cycle of a slot.
    logic               decide;
    logic [DWELL_W-1:0] dwell_eff;
    assign decide    = (state_reg == S_IDLE) || (timer_reg == DWELL_W'(1));
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Candidate gi is the channel gi+1 positions after last (mod 6), so the
    // channel in last itself is the sixth and final candidate.
    logic [2:0] cand_idx [6];
    logic [5:0] cand_hit;
    for (genvar gi = 0; gi < 6; gi++) begin : g_cand
        logic [3:0] sum;
        assign sum          = {1'b0, last_reg} + 4'(gi + 1);
        assign cand_idx[gi] = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
        assign cand_hit[gi] = req_mask[cand_idx[gi]];
    end

    // Pick the first requesting candidate in round-robin order.
    logic [2:0] pick;
    always_comb begin
        pick = last_reg;
        for (int k = 5; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick = cand_idx[k];
            end
        end
    end

    // State register plus all registered outputs and bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            last_reg         <= 3'd5;
            timer_reg        <= '0;
            wrap_pending_reg <= 1'b0;
            now_reg          <= 3'd0;
            valid_reg        <= 1'b0;
            start_reg        <= 1'b0;
            frame_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            last_reg         <= last_next;
            timer_reg        <= timer_next;
            wrap_pending_reg <= wrap_pending_next;
            now_reg          <= now_next;
            valid_reg        <= valid_next;
            start_reg        <= start_next;
            frame_reg        <= frame_next;
        end
    end

    // Next-state selection. ALL may repeat only when no channel is waiting.
    always_comb begin
        state_next = state_reg;
        if (decide) begin
            if (!enable) begin
                state_next = S_IDLE;
            end else if (all_on && ((state_reg != S_ALL) || (req_mask == 6'd0))) begin
                state_next = S_ALL;
            end else if (req_mask != 6'd0) begin
                state_next = S_CHAN;
            end else begin
                state_next = S_IDLE;
            end
        end
    end

    // Output and bookkeeping values for the slot being entered (or kept).
    // wrap_pending arms once a channel slot has been served since IDLE, so
    // the first channel slot after IDLE never reports a wrap.
    always_comb begin
        now_next          = now_reg;
        valid_next        = valid_reg;
        start_next        = 1'b0;
        frame_next        = 1'b0;
        last_next         = last_reg;
        wrap_pending_next = wrap_pending_reg;
        timer_next        = (timer_reg == '0) ? timer_reg : timer_reg - DWELL_W'(1);
        if (decide) begin
            case (state_next)
                S_ALL: begin
                    now_next   = 3'd6;
                    valid_next = 1'b1;
                    start_next = 1'b1;
                    timer_next = dwell_eff;
                end
                S_CHAN: begin
                    now_next          = pick;
                    valid_next        = 1'b1;
                    start_next        = 1'b1;
                    frame_next        = wrap_pending_reg && (pick <= last_reg);
                    last_next         = pick;
                    wrap_pending_next = 1'b1;
                    timer_next        = dwell_eff;
                end
                default: begin
                    now_next          = 3'd0;
                    valid_next        = 1'b0;
                    wrap_pending_next = 1'b0;
                    timer_next        = '0;
                end
            endcase
        end
    end

    assign nowCount   = now_reg;
    assign slot_valid = valid_reg;
    assign slot_start = start_reg;
    assign frame_done = frame_reg;

endmodule

// File: tb/tb_ltable_scan_ctrl.sv
// Bench for ltable_scan_ctrl: a slot-level reference model checked against
// the DUT on every falling edge, plus literal slot-sequence checks.
module tb_ltable_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [5:0]  req_mask = 6'd0;
    logic        all_on = 1'b0;
    logic [15:0] dwell = 16'd1;
    logic [2:0]  nowCount;
    logic        slot_valid, slot_start, frame_done;

    int tests = 0;
    int fails = 0;

    ltable_scan_ctrl #(.DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_mask(req_mask),
        .all_on(all_on), .dwell(dwell), .nowCount(nowCount),
        .slot_valid(slot_valid), .slot_start(slot_start), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: what kind of slot is running, how many cycles remain,
    // the last channel served, and whether a channel ran since idle.
    int   m_kind;   // 0 none, 1 channel, 2 all-on
    int   m_left;
    int   m_last;
    bit   m_armed;
    int   e_now;
    bit   e_valid, e_start, e_frame;

    task automatic model_reset();
        m_kind = 0; m_left = 0; m_last = 5; m_armed = 0;
        e_now = 0; e_valid = 0; e_start = 0; e_frame = 0;
    endtask

    task automatic model_go_idle();
        m_kind = 0; m_left = 0; m_armed = 0; e_now = 0; e_valid = 0;
    endtask

    task automatic model_step();
        int ch;
        int len;
        len = (dwell == 16'd0) ? 1 : int'(dwell);
        e_start = 0;
        e_frame = 0;
        if (m_kind == 0 || m_left == 1) begin
            if (!enable) begin
                model_go_idle();
            end else if (all_on && (m_kind != 2 || req_mask == 6'd0)) begin
                m_kind = 2; m_left = len; e_now = 6; e_valid = 1; e_start = 1;
            end else if (req_mask != 6'd0) begin
                ch = m_last;
                for (int k = 6; k >= 1; k--) begin
                    if (req_mask[(m_last + k) % 6]) ch = (m_last + k) % 6;
                end
                e_frame = m_armed && (ch <= m_last);
                m_last  = ch;
                m_armed = 1;
                m_kind  = 1; m_left = len; e_now = ch; e_valid = 1; e_start = 1;
            end else begin
                model_go_idle();
            end
        end else begin
            m_left--;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("nowCount", int'(nowCount), e_now);
            check("slot_valid", int'(slot_valid), int'(e_valid));
            check("slot_start", int'(slot_start), int'(e_start));
            check("frame_done", int'(frame_done), int'(e_frame));
        end
    end

    // Log of slot starts: {frame_done, nowCount}.
    int slog[$];
    initial begin
        forever begin
            @(negedge clk);
            if (slot_start) begin
                slog.push_back(int'(frame_done) * 8 + int'(nowCount));
                $display("[TB] slot start t=%0t now=%0d frame=%0b", $time, nowCount, frame_done);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_log(string name, int exp_q[$]);
        check({name, "_count"}, slog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < slog.size(); i++) begin
            check($sformatf("%s_%0d", name, i), slog[i], exp_q[i]);
        end
    endtask

    initial begin
        // Reset, then the basic round robin with dwell 3.
        tick(2);
        rst_n = 1'b1;
        check("reset_now", int'(nowCount), 0);
        check("reset_valid", int'(slot_valid), 0);
        enable = 1'b1; req_mask = 6'b111111; dwell = 16'd3;
        slog.delete();
        tick(19);
        check_log("rr", '{0, 1, 2, 3, 4, 5, 8 + 0});

        // Sparse mask 100100 with dwell 2.
        req_mask = 6'b100100; dwell = 16'd2;
        slog.delete();
        tick(9);
        check_log("sparse", '{2, 5, 8 + 2, 5});
        // Mid-slot mask change waits for the slot boundary.
        req_mask = 6'b000001;
        slog.delete();
        tick(1);
        check("midslot_hold_now", int'(nowCount), 5);
        check("midslot_no_start", slog.size(), 0);
        tick(3);
        check_log("maskchg", '{8 + 0, 8 + 0});

        // All-on interleave from a fresh reset.
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        enable = 1'b1; req_mask = 6'b000011; all_on = 1'b1; dwell = 16'd1;
        slog.delete();
        tick(6);
        check_log("allon", '{6, 0, 6, 1, 6, 8 + 0});

        // All-on with an empty mask repeats with dwell 4.
        req_mask = 6'b000000; dwell = 16'd4;
        slog.delete();
        tick(13);
        check_log("allrep", '{6, 6, 6, 6});

        // Dwell zero gives one-cycle slots.
        all_on = 1'b0; req_mask = 6'b111111; dwell = 16'd0;
        slog.delete();
        tick(9);
        check_log("dwell0", '{1, 2, 3, 4, 5, 8 + 0});

        // Drop enable mid-slot: the dwell-5 slot for channel 1 runs to its end.
        dwell = 16'd5;
        tick(2);
        enable = 1'b0;
        tick(3);
        check("stop_last_valid", int'(slot_valid), 1);
        check("stop_last_now", int'(nowCount), 1);
        tick(1);
        check("stop_idle_valid", int'(slot_valid), 0);
        check("stop_idle_now", int'(nowCount), 0);
        enable = 1'b1;
        slog.delete();
        tick(2);
        check_log("resume", '{2});

        // Async reset while channel 3 is being served.
        req_mask = 6'b001000;
        tick(5);
        check("pre_reset_now", int'(nowCount), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_now", int'(nowCount), 0);
        check("async_valid", int'(slot_valid), 0);
        check("async_start", int'(slot_start), 0);
        check("async_frame", int'(frame_done), 0);
        rst_n = 1'b1;
        req_mask = 6'b111111;
        slog.delete();
        tick(3);
        check_log("after_rst", '{0});
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
